// File: rtl/reg_writeback_pkg.sv
// rtl/reg_writeback_pkg.sv - shared types and helpers for the register writeback stage
package reg_writeback_pkg;

    localparam int RISCV_WORD_WIDTH = 32;
    localparam int GP_REG_COUNT     = 32;
    localparam int REG_ADDR_W       = $clog2(GP_REG_COUNT);

    function automatic logic [GP_REG_COUNT-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
        logic [GP_REG_COUNT-1:0] r;
        r     = '0;
        r[rd] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// rtl/reg_writeback_wb_fifo.sv - in-order buffer for load results that lost arbitration
module wb_fifo
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [REG_ADDR_W-1:0]         push_rd,
    input  logic [RISCV_WORD_WIDTH-1:0]   push_data,
    input  logic                          pop,
    output logic [REG_ADDR_W-1:0]         head_rd,
    output logic [RISCV_WORD_WIDTH-1:0]   head_data,
    output logic [CNT_W-1:0]              count,
    output logic [DEPTH-1:0]              entry_valid,
    output logic [DEPTH*REG_ADDR_W-1:0]   entry_rd
);

    logic [REG_ADDR_W-1:0]       mem_rd   [DEPTH];
    logic [RISCV_WORD_WIDTH-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_rd   = mem_rd[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry_rd
        assign entry_rd[g*REG_ADDR_W +: REG_ADDR_W] = mem_rd[g];
    end

    // Entry storage needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= push_rd;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and per-entry valid bits; reset drops all buffered loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (pop) begin
                rd_ptr              <= ptr_next(rd_ptr);
                entry_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr              <= ptr_next(wr_ptr);
                entry_valid[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - arbitrates ALU and load results onto the single register-file write port
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid_i,
    input  logic [REG_ADDR_W-1:0]         alu_rd_i,
    input  logic [RISCV_WORD_WIDTH-1:0]   alu_data_i,
    input  logic                          lsu_valid_i,
    output logic                          lsu_ready_o,
    input  logic [REG_ADDR_W-1:0]         lsu_rd_i,
    input  logic [RISCV_WORD_WIDTH-1:0]   lsu_data_i,
    output logic                          write_en_o,
    output logic [REG_ADDR_W-1:0]         write_addr_o,
    output logic [RISCV_WORD_WIDTH-1:0]   write_data_o,
    output logic [GP_REG_COUNT-1:0]       pending_mask_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                        lsu_fire;
    logic                        direct;
    logic                        push;
    logic                        pop;
    logic                        sel_valid;
    logic [REG_ADDR_W-1:0]       sel_rd;
    logic [RISCV_WORD_WIDTH-1:0] sel_data;
    logic [REG_ADDR_W-1:0]       head_rd;
    logic [RISCV_WORD_WIDTH-1:0] head_data;
    logic [CNT_W-1:0]            count;
    logic [DEPTH-1:0]            entry_valid;
    logic [DEPTH*REG_ADDR_W-1:0] entry_rd;

    // Ready depends only on registered occupancy, so a full FIFO never falls through.
    assign lsu_ready_o = rst_n && (count < CNT_W'(DEPTH));
    assign lsu_fire    = lsu_valid_i && lsu_ready_o;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_rd     (lsu_rd_i),
        .push_data   (lsu_data_i),
        .pop         (pop),
        .head_rd     (head_rd),
        .head_data   (head_data),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    // Source select: ALU first, then buffered loads in order, then a direct load.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        pop       = 1'b0;
        direct    = 1'b0;
        if (alu_valid_i) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd_i;
            sel_data  = alu_data_i;
        end else if (count != '0) begin
            sel_valid = 1'b1;
            sel_rd    = head_rd;
            sel_data  = head_data;
            pop       = 1'b1;
        end else if (lsu_fire) begin
            sel_valid = 1'b1;
            sel_rd    = lsu_rd_i;
            sel_data  = lsu_data_i;
            direct    = 1'b1;
        end
        push = lsu_fire && !direct && (lsu_rd_i != '0);
    end

    // Registered write request; r0 targets are consumed without a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_en_o   <= 1'b0;
            write_addr_o <= '0;
            write_data_o <= '0;
        end else begin
            write_en_o <= sel_valid && (sel_rd != '0);
            if (sel_valid && (sel_rd != '0)) begin
                write_addr_o <= sel_rd;
                write_data_o <= sel_data;
            end
        end
    end

    // Destinations still owed to the register file: buffered loads plus the current write.
    always_comb begin
        pending_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_mask_o = pending_mask_o | reg_onehot(entry_rd[i*REG_ADDR_W +: REG_ADDR_W]);
            end
        end
        if (write_en_o) begin
            pending_mask_o = pending_mask_o | reg_onehot(write_addr_o);
        end
        pending_mask_o[0] = 1'b0;
    end

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed self-checking bench for reg_writeback
module tb_reg_writeback;
    import reg_writeback_pkg::*;

    logic                        clk;
    logic                        rst_n;
    logic                        alu_valid;
    logic [REG_ADDR_W-1:0]       alu_rd;
    logic [RISCV_WORD_WIDTH-1:0] alu_data;
    logic                        lsu_valid;
    logic                        lsu_ready;
    logic [REG_ADDR_W-1:0]       lsu_rd;
    logic [RISCV_WORD_WIDTH-1:0] lsu_data;
    logic                        write_en;
    logic [REG_ADDR_W-1:0]       write_addr;
    logic [RISCV_WORD_WIDTH-1:0] write_data;
    logic [GP_REG_COUNT-1:0]     pending_mask;

    int vectors;
    int miscompares;

    reg_writeback #(.DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid_i    (alu_valid),
        .alu_rd_i       (alu_rd),
        .alu_data_i     (alu_data),
        .lsu_valid_i    (lsu_valid),
        .lsu_ready_o    (lsu_ready),
        .lsu_rd_i       (lsu_rd),
        .lsu_data_i     (lsu_data),
        .write_en_o     (write_en),
        .write_addr_o   (write_addr),
        .write_data_o   (write_data),
        .pending_mask_o (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        lsu_valid = 1'b0;
        lsu_rd    = '0;
        lsu_data  = '0;
    endtask

    task automatic drive_alu(input int rd, input logic [31:0] data);
        alu_valid = 1'b1;
        alu_rd    = REG_ADDR_W'(rd);
        alu_data  = data;
    endtask

    task automatic drive_lsu(input int rd, input logic [31:0] data);
        lsu_valid = 1'b1;
        lsu_rd    = REG_ADDR_W'(rd);
        lsu_data  = data;
    endtask

    task automatic check_wr(input string tag, input logic en, input int addr, input logic [31:0] data);
        check({tag, ".en"}, 64'(write_en), 64'(en));
        if (en) begin
            check({tag, ".addr"}, 64'(write_addr), 64'(addr));
            check({tag, ".data"}, 64'(write_data), 64'(data));
        end
    endtask

    int lsu_rds  [3] = '{3, 4, 6};
    int bp_ready [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    int bp_addr  [7] = '{10, 11, 12, 13, 3, 4, 6};
    int lsu_idx;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        idle();

        // reset state
        cyc();
        cyc();
        check("rst.en",   64'(write_en),     64'd0);
        check("rst.addr", 64'(write_addr),   64'd0);
        check("rst.data", 64'(write_data),   64'd0);
        check("rst.mask", 64'(pending_mask), 64'd0);
        check("rst.rdy",  64'(lsu_ready),    64'd0);
        rst_n = 1'b1;
        #1;
        check("rst.rdy_after", 64'(lsu_ready), 64'd1);

        // ALU only
        drive_alu(5, 32'hDEADBEEF);
        cyc();
        idle();
        check_wr("alu.c1", 1'b1, 5, 32'hDEADBEEF);
        check("alu.mask1", 64'(pending_mask), 64'h20);
        cyc();
        check("alu.en2",   64'(write_en),     64'd0);
        check("alu.mask2", 64'(pending_mask), 64'd0);
        check("alu.hold",  64'(write_data),   64'hDEADBEEF);

        // collision: ALU wins, load buffered
        drive_alu(1, 32'h11);
        drive_lsu(2, 32'h22);
        check("col.rdy", 64'(lsu_ready), 64'd1);
        cyc();
        idle();
        check_wr("col.c1", 1'b1, 1, 32'h11);
        check("col.mask1", 64'(pending_mask), 64'h6);
        cyc();
        check_wr("col.c2", 1'b1, 2, 32'h22);
        check("col.mask2", 64'(pending_mask), 64'h4);
        cyc();
        check("col.en3",   64'(write_en),     64'd0);
        check("col.mask3", 64'(pending_mask), 64'd0);

        // direct path: empty FIFO, no ALU
        drive_lsu(9, 32'h99);
        cyc();
        idle();
        check_wr("dir.c1", 1'b1, 9, 32'h99);
        check("dir.mask", 64'(pending_mask), 64'h200);
        cyc();
        check("dir.en2", 64'(write_en), 64'd0);

        // backpressure with DEPTH 2
        lsu_idx = 0;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive_alu(10 + c, 32'hA0 + 32'(c));
            else begin
                alu_valid = 1'b0;
                alu_rd    = '0;
                alu_data  = '0;
            end
            if (lsu_idx < 3) drive_lsu(lsu_rds[lsu_idx], 32'(lsu_rds[lsu_idx]));
            else begin
                lsu_valid = 1'b0;
                lsu_rd    = '0;
                lsu_data  = '0;
            end
            check($sformatf("bp.rdy%0d", c), 64'(lsu_ready), 64'(bp_ready[c]));
            if (lsu_idx < 3 && bp_ready[c] != 0) lsu_idx++;
            cyc();
            if (c < 4) check_wr($sformatf("bp.w%0d", c), 1'b1, bp_addr[c], 32'hA0 + 32'(c));
            else if (c < 7) check_wr($sformatf("bp.w%0d", c), 1'b1, bp_addr[c], 32'(bp_addr[c]));
            else check("bp.en7", 64'(write_en), 64'd0);
            if (c == 1) check("bp.mask1", 64'(pending_mask), 64'h818);
        end
        idle();

        // r0 from both sources
        drive_alu(0, 32'hFFFF_FFFF);
        drive_lsu(0, 32'h1234);
        check("r0.rdy", 64'(lsu_ready), 64'd1);
        cyc();
        idle();
        check("r0.en1",   64'(write_en),     64'd0);
        check("r0.mask1", 64'(pending_mask), 64'd0);
        check("r0.rdy1",  64'(lsu_ready),    64'd1);
        cyc();
        check("r0.en2",   64'(write_en),     64'd0);

        // simultaneous push/pop at count 1
        drive_alu(12, 32'hCC);
        drive_lsu(5, 32'h55);
        cyc();
        idle();
        check_wr("pp.a", 1'b1, 12, 32'hCC);
        drive_lsu(7, 32'h7);
        check("pp.rdy", 64'(lsu_ready), 64'd1);
        cyc();
        idle();
        check_wr("pp.b", 1'b1, 5, 32'h55);
        check("pp.maskb", 64'(pending_mask), 64'hA0);
        check("pp.rdyb",  64'(lsu_ready),    64'd1);
        cyc();
        check_wr("pp.c", 1'b1, 7, 32'h7);
        check("pp.maskc", 64'(pending_mask), 64'h80);
        cyc();
        check("pp.en_d", 64'(write_en), 64'd0);

        // reset mid-flight: two buffered loads plus an active write
        drive_alu(1, 32'h1);
        drive_lsu(2, 32'h2);
        cyc();
        drive_alu(3, 32'h3);
        drive_lsu(4, 32'h4);
        cyc();
        idle();
        check("mr.rdy_full", 64'(lsu_ready), 64'd0);
        check("mr.mask_pre", 64'(pending_mask), 64'h1C);
        rst_n = 1'b0;
        #1;
        check("mr.rdy_rst", 64'(lsu_ready), 64'd0);
        cyc();
        check("mr.en",   64'(write_en),     64'd0);
        check("mr.addr", 64'(write_addr),   64'd0);
        check("mr.data", 64'(write_data),   64'd0);
        check("mr.mask", 64'(pending_mask), 64'd0);
        rst_n = 1'b1;
        #1;
        check("mr.rdy_post", 64'(lsu_ready), 64'd1);
        cyc();
        check("mr.en1", 64'(write_en), 64'd0);
        cyc();
        check("mr.en2",   64'(write_en),     64'd0);
        check("mr.mask2", 64'(pending_mask), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
